// File: rtl/cim_pkg.sv
// Shared CIM definitions: input-buffer FSM state type and the geometry
// helpers that fix how producer lanes map onto crossbar rows.
package cim_pkg;

   typedef enum logic [1:0] {
      s_ibuf_fill   = 2'd0,
      s_ibuf_full   = 2'd1,
      s_ibuf_stream = 2'd2
   } t_ibuf_state;

   function automatic int ceil_div(input int num, input int den);
      return (num + den - 1) / den;
   endfunction

   // Elements carried by one lane group: one crossbar row per activation bit.
   function automatic int calc_elements_per_tile(input int xbar_size, input int data_size);
      return xbar_size / data_size;
   endfunction

   // Write beats needed to cover every element of a lane group.
   function automatic int calc_num_addr(input int elements_per_tile, input int num_channels);
      return ceil_div(elements_per_tile, num_channels);
   endfunction

   // Crossbar tiles stacked vertically to hold the whole input vector.
   function automatic int calc_v_cim_tiles(input int input_neurons, input int xbar_size);
      return ceil_div(input_neurons, xbar_size);
   endfunction

endpackage

// File: rtl/ibuf_bitplane_mux.sv
// Selects one bit of every stored activation and lays the result out as a
// [tile][row] bit-plane for the crossbars. Output is forced to zero when
// no plane is being presented.
module ibuf_bitplane_mux #(
   parameter int DATA_SIZE   = 8,
   parameter int V_CIM_TILES = 2,
   parameter int XBAR_SIZE   = 256,
   parameter int BW          = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1
) (
   input  logic [V_CIM_TILES*XBAR_SIZE-1:0][DATA_SIZE-1:0] store_i,
   input  logic [BW-1:0]                                   bit_i,
   input  logic                                            en_i,
   output logic [V_CIM_TILES-1:0][XBAR_SIZE-1:0]           plane_o
);

   // Element t*XBAR_SIZE+r drives row r of tile t.
   always_comb begin
      plane_o = '0;
      for (int t = 0; t < V_CIM_TILES; t++) begin
         for (int r = 0; r < XBAR_SIZE; r++) begin
            plane_o[t][r] = en_i & store_i[t*XBAR_SIZE + r][bit_i];
         end
      end
   end

endmodule

// File: rtl/fc_ibuf.sv
// Input buffer for a fully-connected CIM layer. Collects one input vector
// from the previous layer's lane groups, then streams it to the crossbars
// as DATA_SIZE bit-planes, LSB first, one plane per cycle.
//
// Handshakes: upstream may write a beat whenever o_ready=1 and
// i_write_enable=1 in the same cycle; beats offered while o_ready=0 are
// dropped silently. Downstream starts a stream by holding i_cim_ready=1
// for one cycle while the buffer is full; after that the crossbars must
// take one plane per cycle with no back-pressure while o_cim_valid=1.
module fc_ibuf
   import cim_pkg::*;
#(
   parameter  int DATA_SIZE         = 8,
   parameter  int INPUT_NEURONS     = 512,
   parameter  int XBAR_SIZE         = 256,
   parameter  int PREV_H_CIM_TILES  = 16,
   parameter  int NUM_CHANNELS      = 1,
   localparam int ELEMENTS_PER_TILE = calc_elements_per_tile(XBAR_SIZE, DATA_SIZE),
   localparam int NUM_ADDR          = calc_num_addr(ELEMENTS_PER_TILE, NUM_CHANNELS),
   localparam int V_CIM_TILES       = calc_v_cim_tiles(INPUT_NEURONS, XBAR_SIZE),
   localparam int BW                = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1
) (
   input  logic                                                     clk,
   input  logic                                                     rst,
   input  logic [PREV_H_CIM_TILES-1:0][NUM_CHANNELS-1:0][DATA_SIZE-1:0] i_data,
   input  logic                                                     i_write_enable,
   output logic                                                     o_ready,
   input  logic                                                     i_cim_ready,
   output logic                                                     o_cim_start,
   output logic                                                     o_cim_valid,
   output logic [V_CIM_TILES-1:0][XBAR_SIZE-1:0]                    o_cim_data,
   output logic [BW-1:0]                                            o_cim_bit,
   output logic                                                     o_cim_last,
   output t_ibuf_state                                              o_state
);

   localparam int NUM_ELEMS = V_CIM_TILES * XBAR_SIZE;
   localparam int AW        = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1;

   t_ibuf_state                          state_q, state_d;
   logic [AW-1:0]                        ptr_q, ptr_d;
   logic [BW-1:0]                        bit_q, bit_d;
   logic [NUM_ELEMS-1:0][DATA_SIZE-1:0]  mem_q, mem_d;
   logic                                 wr_accept;
   logic                                 last_beat;
   logic                                 last_plane;
   logic                                 cim_valid;

   assign wr_accept  = (state_q == s_ibuf_fill) && i_write_enable;
   assign last_beat  = (ptr_q == AW'(NUM_ADDR - 1));
   assign last_plane = (bit_q == BW'(DATA_SIZE - 1));

   // State register; reset aborts any fill or stream immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= s_ibuf_fill;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: fill until the last beat, wait for the crossbars, stream.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         s_ibuf_fill:   if (wr_accept && last_beat) state_d = s_ibuf_full;
         s_ibuf_full:   if (i_cim_ready)            state_d = s_ibuf_stream;
         s_ibuf_stream: if (last_plane)             state_d = s_ibuf_fill;
         default:                                   state_d = s_ibuf_fill;
      endcase
   end

   // Outputs decoded from registered state and counters only.
   always_comb begin
      o_ready     = 1'b0;
      cim_valid   = 1'b0;
      o_cim_start = 1'b0;
      o_cim_last  = 1'b0;
      unique case (state_q)
         s_ibuf_fill: o_ready = 1'b1;
         s_ibuf_stream: begin
            cim_valid   = 1'b1;
            o_cim_start = (bit_q == '0);
            o_cim_last  = last_plane;
         end
         default: ;
      endcase
   end

   assign o_cim_valid = cim_valid;
   assign o_cim_bit   = bit_q;
   assign o_state     = state_q;

   // Write pointer advances per accepted beat; plane counter per streamed plane.
   always_comb begin
      ptr_d = ptr_q;
      bit_d = bit_q;
      if (wr_accept) begin
         ptr_d = last_beat ? '0 : ptr_q + 1'b1;
      end
      if (state_q == s_ibuf_full) begin
         bit_d = '0;
      end
      if (state_q == s_ibuf_stream) begin
         bit_d = last_plane ? '0 : bit_q + 1'b1;
         if (last_plane) ptr_d = '0;
      end
   end

   // Storage write: each element has exactly one (lane group, beat, channel)
   // source. Elements past INPUT_NEURONS are never written, so they stay
   // zero and act as padding rows in the last tile.
   always_comb begin
      mem_d = mem_q;
      for (int e = 0; e < NUM_ELEMS; e++) begin
         if ((e < INPUT_NEURONS) && ((e / ELEMENTS_PER_TILE) < PREV_H_CIM_TILES)) begin
            if (wr_accept && (ptr_q == AW'((e % ELEMENTS_PER_TILE) / NUM_CHANNELS))) begin
               mem_d[e] = i_data[e / ELEMENTS_PER_TILE][(e % ELEMENTS_PER_TILE) % NUM_CHANNELS];
            end
         end
      end
   end

   // Pointer, plane counter and storage registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q <= '0;
         bit_q <= '0;
         mem_q <= '0;
      end else begin
         ptr_q <= ptr_d;
         bit_q <= bit_d;
         mem_q <= mem_d;
      end
   end

   ibuf_bitplane_mux #(
      .DATA_SIZE   (DATA_SIZE),
      .V_CIM_TILES (V_CIM_TILES),
      .XBAR_SIZE   (XBAR_SIZE),
      .BW          (BW)
   ) u_mux (
      .store_i (mem_q),
      .bit_i   (bit_q),
      .en_i    (cim_valid),
      .plane_o (o_cim_data)
   );

endmodule

// File: tb/tb_fc_ibuf.sv
// Bench for fc_ibuf: two instances (512 and 300 input neurons) share one
// stimulus stream; a vector-level model predicts every output cycle.
module tb_fc_ibuf;
   import cim_pkg::*;

   localparam int DS       = 8;
   localparam int NE       = 512;
   localparam int NE_SMALL = 300;
   localparam int XB       = 256;
   localparam int PH       = 16;
   localparam int NC       = 1;
   localparam int EPT      = 32;
   localparam int NA       = 32;
   localparam int VT       = 2;
   localparam int BW       = 3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [PH-1:0][NC-1:0][DS-1:0] i_data = '0;
   logic                          i_write_enable = 1'b0;
   logic                          i_cim_ready = 1'b0;

   logic              ready0, start0, valid0, last0;
   logic [BW-1:0]     bit0;
   logic [VT-1:0][XB-1:0] data0;
   t_ibuf_state       state0;
   logic              ready1, start1, valid1, last1;
   logic [BW-1:0]     bit1;
   logic [VT-1:0][XB-1:0] data1;
   t_ibuf_state       state1;

   fc_ibuf #(.DATA_SIZE(DS), .INPUT_NEURONS(NE), .XBAR_SIZE(XB),
             .PREV_H_CIM_TILES(PH), .NUM_CHANNELS(NC)) u_dut (
      .clk(clk), .rst(rst), .i_data(i_data), .i_write_enable(i_write_enable),
      .o_ready(ready0), .i_cim_ready(i_cim_ready), .o_cim_start(start0),
      .o_cim_valid(valid0), .o_cim_data(data0), .o_cim_bit(bit0),
      .o_cim_last(last0), .o_state(state0));

   fc_ibuf #(.DATA_SIZE(DS), .INPUT_NEURONS(NE_SMALL), .XBAR_SIZE(XB),
             .PREV_H_CIM_TILES(PH), .NUM_CHANNELS(NC)) u_dut300 (
      .clk(clk), .rst(rst), .i_data(i_data), .i_write_enable(i_write_enable),
      .o_ready(ready1), .i_cim_ready(i_cim_ready), .o_cim_start(start1),
      .o_cim_valid(valid1), .o_cim_data(data1), .o_cim_bit(bit1),
      .o_cim_last(last1), .o_state(state1));

   // ---------------- scoreboard counters ----------------
   int n_vec = 0;
   int n_err = 0;
   bit checking = 1'b0;

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // mode 0: collecting beats, 1: holding a full vector, 2: streaming planes
   int         m_mode  = 0;
   int         m_beats = 0;
   int         m_plane = 0;
   logic [DS-1:0] m_elem [NE];

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_mode  <= 0;
         m_beats <= 0;
         m_plane <= 0;
         for (int e = 0; e < NE; e++) m_elem[e] <= '0;
      end else begin
         case (m_mode)
            0: if (i_write_enable) begin
               for (int i = 0; i < PH; i++) begin
                  for (int j = 0; j < NC; j++) begin
                     if (m_beats*NC + j < EPT) m_elem[i*EPT + m_beats*NC + j] <= i_data[i][j];
                  end
               end
               if (m_beats == NA-1) begin
                  m_mode  <= 1;
                  m_beats <= 0;
               end else begin
                  m_beats <= m_beats + 1;
               end
            end
            1: if (i_cim_ready) begin
               m_mode  <= 2;
               m_plane <= 0;
            end
            default: begin
               if (m_plane == DS-1) begin
                  m_mode  <= 0;
                  m_beats <= 0;
               end else begin
                  m_plane <= m_plane + 1;
               end
            end
         endcase
      end
   end

   // Plane a layer with n neurons must present: bit m_plane of each element,
   // zero for rows past the vector length.
   function automatic logic [VT-1:0][XB-1:0] exp_plane(input int n);
      logic [VT-1:0][XB-1:0] p;
      p = '0;
      for (int t = 0; t < VT; t++) begin
         for (int r = 0; r < XB; r++) begin
            if (t*XB + r < n) p[t][r] = m_elem[t*XB + r][m_plane];
         end
      end
      return p;
   endfunction

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (checking) begin
         chk("ready0", 512'(ready0), 512'(m_mode == 0));
         chk("valid0", 512'(valid0), 512'(m_mode == 2));
         chk("start0", 512'(start0), 512'(m_mode == 2 && m_plane == 0));
         chk("last0",  512'(last0),  512'(m_mode == 2 && m_plane == DS-1));
         chk("ready1", 512'(ready1), 512'(m_mode == 0));
         chk("valid1", 512'(valid1), 512'(m_mode == 2));
         if (m_mode == 2) begin
            chk("bit0",   512'(bit0), 512'(m_plane));
            chk("bit1",   512'(bit1), 512'(m_plane));
            chk("plane0", data0, exp_plane(NE));
            chk("plane1", data1, exp_plane(NE_SMALL));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic write_beat(input int a, input bit gap);
      for (int i = 0; i < PH; i++)
         for (int j = 0; j < NC; j++)
            i_data[i][j] = 8'((i*EPT + a*NC + j) & 255);
      i_write_enable = 1'b1;
      @(negedge clk);
      i_write_enable = 1'b0;
      if (gap) @(negedge clk);
   endtask

   task automatic write_rand();
      for (int i = 0; i < PH; i++)
         for (int j = 0; j < NC; j++)
            i_data[i][j] = 8'($urandom_range(0, 255));
      i_write_enable = 1'b1;
      @(negedge clk);
      i_write_enable = 1'b0;
   endtask

   task automatic pulse_cim_ready();
      i_cim_ready = 1'b1;
      @(negedge clk);
      i_cim_ready = 1'b0;
   endtask

   task automatic wait_bit(input int k, input int budget);
      int n;
      n = 0;
      while (!(valid0 && bit0 == BW'(k)) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("wait_bit", 512'(valid0 && bit0 == BW'(k)), 512'(1));
   endtask

   // ---------------- stimulus ----------------
   logic [DS-1:0] lit37;
   logic [DS-1:0] lit299;

   initial begin
      lit37  = 8'h25;
      lit299 = 8'h2B;
      repeat (3) @(negedge clk);
      chk("rst_ready", 512'(ready0), 512'(1));
      chk("rst_valid", 512'(valid0), 512'(0));
      chk("rst_start", 512'(start0), 512'(0));
      chk("rst_last",  512'(last0),  512'(0));
      chk("rst_bit",   512'(bit0),   512'(0));
      chk("rst_data",  data0,        512'(0));
      chk("rst_state0", 512'(state0), 512'(s_ibuf_fill));
      chk("rst_state1", 512'(state1), 512'(s_ibuf_fill));
      rst = 1'b1;
      checking = 1'b1;

      // back-to-back fill with the ramp pattern
      for (int a = 0; a < NA-1; a++) write_beat(a, 1'b0);
      chk("ready_before_last", 512'(ready0), 512'(1));
      write_beat(NA-1, 1'b0);
      chk("ready_after_last", 512'(ready0), 512'(0));

      // junk writes while full and while streaming must be ignored
      for (int i = 0; i < PH; i++) i_data[i] = '1;
      i_write_enable = 1'b1;
      repeat (3) @(negedge clk);
      chk("no_valid_while_held", 512'(valid0), 512'(0));
      pulse_cim_ready();
      chk("first_start", 512'(start0), 512'(1));
      chk("first_bit",   512'(bit0),   512'(0));
      for (int k = 0; k < DS; k++) begin
         chk("row37_tile0", 512'(data0[0][37]), 512'(lit37[k]));
         chk("row43_tile1", 512'(data1[1][43]), 512'(lit299[k]));
         chk("pad44_tile1", 512'(data1[1][44]), 512'(0));
         chk("pad255_tile1", 512'(data1[1][255]), 512'(0));
         if (k == DS-1) begin
            chk("last_on_bit7", 512'(last0), 512'(1));
            i_write_enable = 1'b0;
         end
         @(negedge clk);
      end
      chk("ready_after_stream", 512'(ready0), 512'(1));

      // gapped fill: exactly NA accepted beats reach the full state
      for (int a = 0; a < NA-1; a++) write_beat(a, 1'b1);
      chk("gap_ready_before_last", 512'(ready0), 512'(1));
      write_beat(NA-1, 1'b1);
      chk("gap_ready_after_last", 512'(ready0), 512'(0));
      pulse_cim_ready();
      chk("gap_start", 512'(start0), 512'(1));
      repeat (DS) @(negedge clk);

      // reset in the middle of a stream
      for (int a = 0; a < NA; a++) write_rand();
      pulse_cim_ready();
      wait_bit(3, 10);
      #2 rst = 1'b0;
      #1;
      chk("async_valid0", 512'(valid0), 512'(0));
      chk("async_ready0", 512'(ready0), 512'(1));
      chk("async_valid1", 512'(valid1), 512'(0));
      chk("async_ready1", 512'(ready1), 512'(1));
      @(negedge clk);
      rst = 1'b1;
      for (int a = 0; a < NA-1; a++) write_rand();
      i_cim_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("partial_no_stream", 512'(valid0), 512'(0));
      chk("partial_ready", 512'(ready0), 512'(1));
      i_cim_ready = 1'b0;
      write_rand();

      // randomized traffic: gapped writes, stray writes, random crossbar readiness
      repeat (1500) begin
         for (int i = 0; i < PH; i++)
            for (int j = 0; j < NC; j++)
               i_data[i][j] = 8'($urandom_range(0, 255));
         i_write_enable = ($urandom_range(0, 9) < 7);
         i_cim_ready    = ($urandom_range(0, 3) == 0);
         @(negedge clk);
      end
      i_write_enable = 1'b0;
      i_cim_ready    = 1'b0;
      repeat (20) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
